// File: rtl/axi_mem_arbiter.sv
// -----------------------------------------------------------------------------
// axi_mem_arbiter
//
// Merges the icache refill read port and the dcache refill/write-back ports
// onto one AXI4 master. One read burst and one write burst may be outstanding
// at a time. The read and write paths are independent state machines. Read
// data is routed back to the requester by AXI ID.
//
// Build option:
//   ARB_ROUND_ROBIN_EN  when defined, read-arbiter priority alternates between
//                       dcache and icache after each grant. When undefined,
//                       dcache has fixed priority over icache.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   i_ar*/i_r*                    icache read request and read-data beats
//   d_ar*/d_r*                    dcache read request and read-data beats
//   d_aw*/d_w*/d_b*               dcache write address, data and response
//   m_ar*/m_r*                    AXI4 master read address / read data
//   m_aw*/m_w*/m_b*               AXI4 master write address / data / response
// -----------------------------------------------------------------------------
module axi_mem_arbiter #(
  parameter logic [3:0] ID_I       = 4'd0,
  parameter logic [3:0] ID_D       = 4'd1,
  parameter logic [1:0] BURST_INCR = 2'b01
) (
  input  logic        clk,
  input  logic        rst,
  // icache read port
  input  logic        i_arvalid,
  input  logic [31:0] i_araddr,
  input  logic [7:0]  i_arlen,
  output logic        i_arready,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  output logic        i_rlast,
  input  logic        i_rready,
  // dcache read port
  input  logic        d_arvalid,
  input  logic [31:0] d_araddr,
  input  logic [7:0]  d_arlen,
  output logic        d_arready,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_rlast,
  input  logic        d_rready,
  // dcache write port
  input  logic        d_awvalid,
  input  logic [31:0] d_awaddr,
  input  logic [7:0]  d_awlen,
  output logic        d_awready,
  input  logic        d_wvalid,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  input  logic        d_wlast,
  output logic        d_wready,
  output logic        d_bvalid,
  input  logic        d_bready,
  // AXI AR
  output logic [3:0]  m_arid,
  output logic [31:0] m_araddr,
  output logic [7:0]  m_arlen,
  output logic [2:0]  m_arsize,
  output logic [1:0]  m_arburst,
  output logic        m_arvalid,
  input  logic        m_arready,
  // AXI R
  input  logic [3:0]  m_rid,
  input  logic [31:0] m_rdata,
  input  logic [1:0]  m_rresp,
  input  logic        m_rlast,
  input  logic        m_rvalid,
  output logic        m_rready,
  // AXI AW
  output logic [3:0]  m_awid,
  output logic [31:0] m_awaddr,
  output logic [7:0]  m_awlen,
  output logic [2:0]  m_awsize,
  output logic [1:0]  m_awburst,
  output logic        m_awvalid,
  input  logic        m_awready,
  // AXI W
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  output logic        m_wlast,
  output logic        m_wvalid,
  input  logic        m_wready,
  // AXI B
  input  logic [3:0]  m_bid,
  input  logic [1:0]  m_bresp,
  input  logic        m_bvalid,
  output logic        m_bready
);

  // Every transfer is one 32-bit word per beat.
  localparam logic [2:0] SIZE_4B = 3'b010;

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_e;

  // Read path state
  r_state_e    r_state_q,   r_state_d;
  logic        i_arready_q, i_arready_d;
  logic        d_arready_q, d_arready_d;
  logic        m_arvalid_q, m_arvalid_d;
  logic [3:0]  m_arid_q,    m_arid_d;
  logic [31:0] m_araddr_q,  m_araddr_d;
  logic [7:0]  m_arlen_q,   m_arlen_d;
`ifdef ARB_ROUND_ROBIN_EN
  logic        rr_i_prio_q, rr_i_prio_d;
`endif

  // Write path state
  w_state_e    w_state_q,   w_state_d;
  logic        d_awready_q, d_awready_d;
  logic        m_awvalid_q, m_awvalid_d;
  logic [3:0]  m_awid_q,    m_awid_d;
  logic [31:0] m_awaddr_q,  m_awaddr_d;
  logic [7:0]  m_awlen_q,   m_awlen_d;

  logic d_rd_ok;
  logic grant_d;
  logic grant_i;
  logic r_owner_is_d;
  logic r_owner_hit;
  logic r_done;

  // Response codes and the B-channel ID carry no information this block acts on.
  logic unused_ok;
  assign unused_ok = ^{m_rresp, m_bresp, m_bid};

  // ---------------------------------------------------------------------------
  // Read arbitration
  // ---------------------------------------------------------------------------
  always_comb begin
    // A dcache refill must not overtake a write-back of the same line, so the
    // dcache read waits while any write is in flight or being presented.
    d_rd_ok = d_arvalid && (w_state_q == W_IDLE) && !d_awvalid;
`ifdef ARB_ROUND_ROBIN_EN
    grant_i = i_arvalid && (rr_i_prio_q || !d_rd_ok);
    grant_d = d_rd_ok && !grant_i;
`else
    grant_d = d_rd_ok;
    grant_i = i_arvalid && !d_rd_ok;
`endif
  end

  // ---------------------------------------------------------------------------
  // R channel demux: the latched ARID names the owner of the outstanding burst.
  // A beat carrying any other ID is stalled rather than misdelivered.
  // ---------------------------------------------------------------------------
  always_comb begin
    r_owner_is_d = (m_arid_q == ID_D);
    r_owner_hit  = (r_state_q == R_DATA) && (m_rid == m_arid_q);
    m_rready     = r_owner_hit && (r_owner_is_d ? d_rready : i_rready);
    i_rvalid     = r_owner_hit && !r_owner_is_d && m_rvalid;
    d_rvalid     = r_owner_hit &&  r_owner_is_d && m_rvalid;
    r_done       = m_rvalid && m_rready && m_rlast;
  end

  assign i_rdata = m_rdata;
  assign i_rlast = m_rlast;
  assign d_rdata = m_rdata;
  assign d_rlast = m_rlast;

  // ---------------------------------------------------------------------------
  // Read FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    r_state_d   = r_state_q;
    i_arready_d = 1'b0;
    d_arready_d = 1'b0;
    m_arvalid_d = m_arvalid_q;
    m_arid_d    = m_arid_q;
    m_araddr_d  = m_araddr_q;
    m_arlen_d   = m_arlen_q;
`ifdef ARB_ROUND_ROBIN_EN
    rr_i_prio_d = rr_i_prio_q;
`endif
    unique case (r_state_q)
      R_IDLE: begin
        if (grant_d) begin
          d_arready_d = 1'b1;
          m_arvalid_d = 1'b1;
          m_arid_d    = ID_D;
          m_araddr_d  = d_araddr;
          m_arlen_d   = d_arlen;
          r_state_d   = R_ADDR;
`ifdef ARB_ROUND_ROBIN_EN
          rr_i_prio_d = 1'b1;
`endif
        end else if (grant_i) begin
          i_arready_d = 1'b1;
          m_arvalid_d = 1'b1;
          m_arid_d    = ID_I;
          m_araddr_d  = i_araddr;
          m_arlen_d   = i_arlen;
          r_state_d   = R_ADDR;
`ifdef ARB_ROUND_ROBIN_EN
          rr_i_prio_d = 1'b0;
`endif
        end
      end
      R_ADDR: begin
        if (m_arvalid_q && m_arready) begin
          m_arvalid_d = 1'b0;
          r_state_d   = R_DATA;
        end
      end
      R_DATA: begin
        if (r_done) begin
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Write FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_d   = w_state_q;
    d_awready_d = 1'b0;
    m_awvalid_d = m_awvalid_q;
    m_awid_d    = m_awid_q;
    m_awaddr_d  = m_awaddr_q;
    m_awlen_d   = m_awlen_q;
    unique case (w_state_q)
      W_IDLE: begin
        if (d_awvalid) begin
          d_awready_d = 1'b1;
          m_awvalid_d = 1'b1;
          m_awid_d    = ID_D;
          m_awaddr_d  = d_awaddr;
          m_awlen_d   = d_awlen;
          w_state_d   = W_ADDR;
        end
      end
      W_ADDR: begin
        if (m_awvalid_q && m_awready) begin
          m_awvalid_d = 1'b0;
          w_state_d   = W_DATA;
        end
      end
      W_DATA: begin
        if (d_wvalid && m_wready && d_wlast) begin
          w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (m_bvalid && d_bready) begin
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // W and B channels are pass-through, opened only in their own phase so that
  // early write beats and stray responses are held off.
  always_comb begin
    m_wvalid = (w_state_q == W_DATA) && d_wvalid;
    d_wready = (w_state_q == W_DATA) && m_wready;
    m_bready = (w_state_q == W_RESP) && d_bready;
    d_bvalid = (w_state_q == W_RESP) && m_bvalid;
  end

  assign m_wdata = d_wdata;
  assign m_wstrb = d_wstrb;
  assign m_wlast = d_wlast;

  // ---------------------------------------------------------------------------
  // State registers for both FSMs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state_q   <= R_IDLE;
      i_arready_q <= 1'b0;
      d_arready_q <= 1'b0;
      m_arvalid_q <= 1'b0;
      m_arid_q    <= 4'd0;
      m_araddr_q  <= 32'd0;
      m_arlen_q   <= 8'd0;
`ifdef ARB_ROUND_ROBIN_EN
      rr_i_prio_q <= 1'b0;
`endif
      w_state_q   <= W_IDLE;
      d_awready_q <= 1'b0;
      m_awvalid_q <= 1'b0;
      m_awid_q    <= 4'd0;
      m_awaddr_q  <= 32'd0;
      m_awlen_q   <= 8'd0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples its pre-edge
      // value, independent of statement order within this block.
      r_state_q   <= r_state_d;
      i_arready_q <= i_arready_d;
      d_arready_q <= d_arready_d;
      m_arvalid_q <= m_arvalid_d;
      m_arid_q    <= m_arid_d;
      m_araddr_q  <= m_araddr_d;
      m_arlen_q   <= m_arlen_d;
`ifdef ARB_ROUND_ROBIN_EN
      rr_i_prio_q <= rr_i_prio_d;
`endif
      w_state_q   <= w_state_d;
      d_awready_q <= d_awready_d;
      m_awvalid_q <= m_awvalid_d;
      m_awid_q    <= m_awid_d;
      m_awaddr_q  <= m_awaddr_d;
      m_awlen_q   <= m_awlen_d;
    end
  end

  assign i_arready = i_arready_q;
  assign d_arready = d_arready_q;
  assign m_arvalid = m_arvalid_q;
  assign m_arid    = m_arid_q;
  assign m_araddr  = m_araddr_q;
  assign m_arlen   = m_arlen_q;
  assign m_arsize  = SIZE_4B;
  assign m_arburst = BURST_INCR;

  assign d_awready = d_awready_q;
  assign m_awvalid = m_awvalid_q;
  assign m_awid    = m_awid_q;
  assign m_awaddr  = m_awaddr_q;
  assign m_awlen   = m_awlen_q;
  assign m_awsize  = SIZE_4B;
  assign m_awburst = BURST_INCR;

  // A read beat tagged with an ID other than the outstanding burst's is a bus
  // protocol error; the beat is held (m_rready stays low) and flagged here.
  rid_matches_owner: assert property (@(posedge clk) disable iff (rst)
    ((r_state_q == R_DATA) && m_rvalid) |-> (m_rid == m_arid_q));

endmodule

// File: tb/tb_axi_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_axi_mem_arbiter
//
// Directed bench for axi_mem_arbiter. The bench plays the AXI slave and both
// cache clients from one linear initial block. Expected read beats and write
// beats are pushed to scoreboard queues when driven and popped by monitors
// when the DUT hands them over. Priority expectations follow the
// ARB_ROUND_ROBIN_EN build option.
// -----------------------------------------------------------------------------
module tb_axi_mem_arbiter;

  localparam logic [3:0] ID_I = 4'd0;
  localparam logic [3:0] ID_D = 4'd1;

  logic        clk;
  logic        rst;
  logic        i_arvalid, i_arready, i_rvalid, i_rlast, i_rready;
  logic [31:0] i_araddr, i_rdata;
  logic [7:0]  i_arlen;
  logic        d_arvalid, d_arready, d_rvalid, d_rlast, d_rready;
  logic [31:0] d_araddr, d_rdata;
  logic [7:0]  d_arlen;
  logic        d_awvalid, d_awready, d_wvalid, d_wlast, d_wready, d_bvalid, d_bready;
  logic [31:0] d_awaddr, d_wdata;
  logic [7:0]  d_awlen;
  logic [3:0]  d_wstrb;
  logic [3:0]  m_arid, m_rid, m_awid, m_bid, m_wstrb;
  logic [31:0] m_araddr, m_rdata, m_awaddr, m_wdata;
  logic [7:0]  m_arlen, m_awlen;
  logic [2:0]  m_arsize, m_awsize;
  logic [1:0]  m_arburst, m_awburst, m_rresp, m_bresp;
  logic        m_arvalid, m_arready, m_rlast, m_rvalid, m_rready;
  logic        m_awvalid, m_awready, m_wlast, m_wvalid, m_wready, m_bvalid, m_bready;

  int checks = 0;
  int errors = 0;
  bit last_d = 1'b0;   // last read grant went to dcache

  logic [32:0] i_q[$];  // {rlast, rdata}
  logic [32:0] d_q[$];
  logic [36:0] w_q[$];  // {wlast, wstrb, wdata}

  axi_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .i_arvalid(i_arvalid), .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arready(i_arready),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_rlast(i_rlast), .i_rready(i_rready),
    .d_arvalid(d_arvalid), .d_araddr(d_araddr), .d_arlen(d_arlen), .d_arready(d_arready),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_rlast(d_rlast), .d_rready(d_rready),
    .d_awvalid(d_awvalid), .d_awaddr(d_awaddr), .d_awlen(d_awlen), .d_awready(d_awready),
    .d_wvalid(d_wvalid), .d_wdata(d_wdata), .d_wstrb(d_wstrb), .d_wlast(d_wlast),
    .d_wready(d_wready), .d_bvalid(d_bvalid), .d_bready(d_bready),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
    .m_awburst(m_awburst), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid),
    .m_wready(m_wready),
    .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard monitors, sampled on the falling edge
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    if (!rst) begin
      if (i_rvalid) begin
        if (i_q.size() == 0) check("i_spurious_rvalid", i_rvalid, 1'b0);
        else if (i_rready) check("i_rbeat", {i_rlast, i_rdata}, i_q.pop_front());
      end
      if (d_rvalid) begin
        if (d_q.size() == 0) check("d_spurious_rvalid", d_rvalid, 1'b0);
        else if (d_rready) check("d_rbeat", {d_rlast, d_rdata}, d_q.pop_front());
      end
      if (m_wvalid) begin
        if (w_q.size() == 0) check("w_spurious_wvalid", m_wvalid, 1'b0);
        else if (m_wready) check("w_beat", {m_wlast, m_wstrb, m_wdata}, w_q.pop_front());
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic raise(input bit is_d, input logic [31:0] a, input logic [7:0] l);
    if (is_d) begin d_arvalid = 1'b1; d_araddr = a; d_arlen = l; end
    else      begin i_arvalid = 1'b1; i_araddr = a; i_arlen = l; end
  endtask

  task automatic wait_grant(input bit is_d);
    logic got;
    got = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if ((is_d ? d_arready : i_arready) === 1'b1) begin got = 1'b1; break; end
    end
    check(is_d ? "d_grant" : "i_grant", got, 1'b1);
    check("loser_arready_low", is_d ? i_arready : d_arready, 1'b0);
    @(posedge clk); #1;
    if (is_d) d_arvalid = 1'b0; else i_arvalid = 1'b0;
    last_d = is_d;
  endtask

  task automatic ar_accept(input int stall, input logic [3:0] id,
                           input logic [31:0] a, input logic [7:0] l);
    logic [48:0] exp_p;
    exp_p = {id, a, l, 3'b010, 2'b01};
    @(negedge clk);
    check("m_arvalid", m_arvalid, 1'b1);
    check("ar_payload", {m_arid, m_araddr, m_arlen, m_arsize, m_arburst}, exp_p);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check("ar_hold_valid", m_arvalid, 1'b1);
      check("ar_hold_payload", {m_arid, m_araddr, m_arlen, m_arsize, m_arburst}, exp_p);
    end
    @(posedge clk); #1; m_arready = 1'b1;
    @(posedge clk); #1; m_arready = 1'b0;
    @(negedge clk);
    check("ar_done", m_arvalid, 1'b0);
  endtask

  task automatic r_burst(input bit is_d, input int n, input logic [31:0] base,
                         input int hold_beat);
    logic got;
    @(posedge clk); #1;
    for (int b = 0; b < n; b++) begin
      m_rvalid = 1'b1;
      m_rid    = is_d ? ID_D : ID_I;
      m_rdata  = base + b;
      m_rlast  = (b == n - 1);
      m_rresp  = (b % 2 == 1) ? 2'b10 : 2'b00;  // error responses still deliver data
      if (is_d) d_q.push_back({b == n - 1, base + b});
      else      i_q.push_back({b == n - 1, base + b});
      if (b == hold_beat) begin
        if (is_d) d_rready = 1'b0; else i_rready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          @(negedge clk);
          check("r_backpressure", {m_rready, is_d ? d_rvalid : i_rvalid}, 2'b01);
        end
        @(posedge clk); #1;
        if (is_d) d_rready = 1'b1; else i_rready = 1'b1;
      end
      got = 1'b0;
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        if (m_rready === 1'b1) begin got = 1'b1; break; end
      end
      check("r_handshake", got, 1'b1);
      @(posedge clk); #1;
    end
    m_rvalid = 1'b0;
    m_rlast  = 1'b0;
    @(negedge clk);
    check("r_queue_drained", is_d ? d_q.size() : i_q.size(), 0);
    check("r_idle_after_last", {i_rvalid, d_rvalid, m_rready}, 3'b000);
  endtask

  task automatic read_txn(input bit is_d, input logic [31:0] a, input logic [7:0] l,
                          input int ar_stall, input logic [31:0] base, input int hold_beat);
    raise(is_d, a, l);
    wait_grant(is_d);
    ar_accept(ar_stall, is_d ? ID_D : ID_I, a, l);
    r_burst(is_d, int'(l) + 1, base, hold_beat);
  endtask

  task automatic pair(input logic [31:0] ai, input logic [31:0] ad);
    bit first_d;
`ifdef ARB_ROUND_ROBIN_EN
    first_d = !last_d;
`else
    first_d = 1'b1;
`endif
    raise(1'b0, ai, 8'd1);
    raise(1'b1, ad, 8'd1);
    wait_grant(first_d);
    ar_accept(0, first_d ? ID_D : ID_I, first_d ? ad : ai, 8'd1);
    r_burst(first_d, 2, first_d ? 32'hD000_0000 : 32'h1000_0100, -1);
    wait_grant(!first_d);
    ar_accept(0, first_d ? ID_I : ID_D, first_d ? ai : ad, 8'd1);
    r_burst(!first_d, 2, first_d ? 32'h1000_0200 : 32'hD000_0200, -1);
  endtask

  task automatic aw_req(input logic [31:0] a, input logic [7:0] l);
    logic got;
    d_awvalid = 1'b1; d_awaddr = a; d_awlen = l;
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (d_awready === 1'b1) begin got = 1'b1; break; end
    end
    check("aw_grant", got, 1'b1);
    @(posedge clk); #1;
    d_awvalid = 1'b0;
  endtask

  task automatic aw_accept(input logic [31:0] a, input logic [7:0] l);
    // An early write beat is offered to prove it is held off before W_DATA.
    d_wvalid = 1'b1; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'hF; d_wlast = 1'b1;
    @(negedge clk);
    check("m_awvalid", m_awvalid, 1'b1);
    check("aw_payload", {m_awid, m_awaddr, m_awlen, m_awsize, m_awburst},
          {ID_D, a, l, 3'b010, 2'b01});
    check("w_before_data", {d_wready, m_wvalid}, 2'b00);
    check("hazard_aw", {d_arready, m_arvalid}, 2'b00);
    @(posedge clk); #1; d_wvalid = 1'b0; d_wlast = 1'b0; m_awready = 1'b1;
    @(posedge clk); #1; m_awready = 1'b0;
  endtask

  task automatic w_burst(input int n, input logic [31:0] base, input logic [3:0] strb);
    for (int b = 0; b < n; b++) begin
      d_wvalid = 1'b1;
      d_wdata  = base + b;
      d_wstrb  = strb;
      d_wlast  = (b == n - 1);
      w_q.push_back({b == n - 1, strb, base + b});
      @(negedge clk);
      check("w_ready", d_wready, 1'b1);
      check("hazard_w", {d_arready, m_arvalid}, 2'b00);
      @(posedge clk); #1;
    end
    d_wvalid = 1'b0;
    d_wlast  = 1'b0;
  endtask

  task automatic b_resp(input logic [1:0] resp);
    m_bvalid = 1'b1; m_bresp = resp; m_bid = ID_D;
    @(negedge clk);
    check("b_forward", {d_bvalid, m_bready}, 2'b11);
    check("hazard_b", d_arready, 1'b0);
    @(posedge clk); #1;
    m_bvalid = 1'b0;
    @(negedge clk);
    check("b_done", {d_bvalid, m_bready}, 2'b00);
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst = 1'b1;
    i_arvalid = 1'b0; i_araddr = '0; i_arlen = '0; i_rready = 1'b1;
    d_arvalid = 1'b0; d_araddr = '0; d_arlen = '0; d_rready = 1'b1;
    d_awvalid = 1'b0; d_awaddr = '0; d_awlen = '0;
    d_wvalid = 1'b0; d_wdata = '0; d_wstrb = '0; d_wlast = 1'b0; d_bready = 1'b1;
    m_arready = 1'b0; m_rid = '0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0; m_rvalid = 1'b0;
    m_awready = 1'b0; m_wready = 1'b1; m_bid = '0; m_bresp = '0; m_bvalid = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_ctrl", {i_arready, d_arready, d_awready, m_arvalid, m_awvalid, m_rready,
                       m_bready, d_wready, d_bvalid, i_rvalid, d_rvalid, m_wvalid}, 12'h000);
    check("rst_ar", {m_arid, m_araddr, m_arlen}, 44'h0);
    check("rst_aw", {m_awid, m_awaddr, m_awlen}, 44'h0);
    check("rst_const", {m_arsize, m_arburst, m_awsize, m_awburst}, {3'b010, 2'b01, 3'b010, 2'b01});
    @(posedge clk); #1;
    rst = 1'b0;

    // Icache-only refill, 4 beats
    read_txn(1'b0, 32'h1C00_0000, 8'd3, 0, 32'h1000_0000, -1);

    // Simultaneous requests: dcache first, icache follows
    pair(32'h0000_0100, 32'h0000_0200);

    // Backpressure: AR stalled 5 cycles, then dcache stalls R mid-burst
    read_txn(1'b0, 32'h0000_4000, 8'd1, 5, 32'h1400_0000, -1);
    read_txn(1'b1, 32'h0000_5000, 8'd3, 0, 32'hD500_0000, 1);

    // Second simultaneous pair (icache-first under round robin)
    pair(32'h0000_0600, 32'h0000_0700);

    // Dirty eviction: refill held until the write-back response completes
    aw_req(32'h8000_0040, 8'd3);
    raise(1'b1, 32'h8000_0080, 8'd0);
    aw_accept(32'h8000_0040, 8'd3);
    w_burst(4, 32'h0000_00A0, 4'hF);
    b_resp(2'b10);
    wait_grant(1'b1);
    ar_accept(0, ID_D, 32'h8000_0080, 8'd0);
    r_burst(1'b1, 1, 32'hDDDD_0000, -1);
    check("w_queue_drained", w_q.size(), 0);

    // Uncached single-beat store
    aw_req(32'h9000_0010, 8'd0);
    aw_accept(32'h9000_0010, 8'd0);
    w_burst(1, 32'h00AB_0000, 4'b0100);
    b_resp(2'b00);
    check("w_queue_drained_uc", w_q.size(), 0);

    // Asynchronous reset during beat 2 of an icache burst
    raise(1'b0, 32'h0000_2000, 8'd3);
    wait_grant(1'b0);
    ar_accept(0, ID_I, 32'h0000_2000, 8'd3);
    @(posedge clk); #1;
    m_rvalid = 1'b1; m_rid = ID_I; m_rdata = 32'h1200_0000; m_rlast = 1'b0; m_rresp = 2'b00;
    i_q.push_back({1'b0, 32'h1200_0000});
    @(negedge clk);
    check("rst_beat1_handshake", m_rready, 1'b1);
    @(posedge clk); #1;
    m_rdata = 32'h1200_0001;
    #2 rst = 1'b1;
    #1;
    check("rst_async_ctrl", {m_rready, i_rvalid, d_rvalid, m_arvalid, i_arready, d_arready,
                             m_awvalid, m_bready}, 8'h00);
    check("rst_async_ar", {m_arid, m_araddr, m_arlen}, 44'h0);
    check("rst_beat2_dropped", i_q.size(), 0);
    m_rvalid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    last_d = 1'b0;

    // Arbitration resumes normally after reset
    read_txn(1'b1, 32'h0000_0300, 8'd0, 0, 32'hD300_0000, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_mem_arbiter.md
Name: axi_mem_arbiter

Overview:
- Sits directly downstream of the icache and dcache miss/write-back interfaces.
- Merges the icache read port and the dcache read and write ports onto a single AXI4 master toward the SoC bus.
- Supports one outstanding read burst and one outstanding write burst; read and write paths are independent FSMs.
- Response data is routed back to the requester by AXI ID.

Parameters:
- ID_I, 4'd0, ARID used for icache reads.
- ID_D, 4'd1, ARID/AWID used for dcache accesses.
- BURST_INCR, 2'b01, value driven on arburst/awburst.

Ports:
- clk  input  1  core clock.
- rst  input  1  asynchronous active-high reset.
- i_arvalid/i_araddr/i_arlen  input  1/32/8  icache read request.
- i_arready  output  1  icache request accepted.
- i_rvalid/i_rdata/i_rlast  output  1/32/1  icache read data beats.
- i_rready  input  1  icache accepts a beat.
- d_arvalid/d_araddr/d_arlen  input  1/32/8  dcache read request.
- d_arready  output  1  dcache read accepted.
- d_rvalid/d_rdata/d_rlast  output  1/32/1  dcache read beats.
- d_rready  input  1  dcache accepts a beat.
- d_awvalid/d_awaddr/d_awlen  input  1/32/8  dcache write address.
- d_awready  output  1  write address accepted.
- d_wvalid/d_wdata/d_wstrb/d_wlast  input  1/32/4/1  dcache write beats.
- d_wready  output  1  write beat accepted.
- d_bvalid  output  1  write response to dcache.
- d_bready  input  1  dcache accepts the response.
- m_arid/m_araddr/m_arlen/m_arsize/m_arburst/m_arvalid  output  4/32/8/3/2/1  AXI AR.
- m_arready  input  1  AXI AR ready.
- m_rid/m_rdata/m_rresp/m_rlast/m_rvalid  input  4/32/2/1/1  AXI R.
- m_rready  output  1  AXI R ready.
- m_awid/m_awaddr/m_awlen/m_awsize/m_awburst/m_awvalid  output  4/32/8/3/2/1  AXI AW.
- m_awready  input  1  AXI AW ready.
- m_wdata/m_wstrb/m_wlast/m_wvalid  output  32/4/1/1  AXI W.
- m_wready  input  1  AXI W ready.
- m_bid/m_bresp/m_bvalid  input  4/2/1  AXI B.
- m_bready  output  1  AXI B ready.

Behaviour:
- Reset (async, rst=1):
  - Both FSMs go to IDLE.
  - All valid/ready outputs are 0.
  - m_araddr/m_awaddr are 0 and m_arlen/m_awlen are 0; m_arid/m_awid are 0.
  - Constant outputs: m_arsize = m_awsize = 3'b010; m_arburst = m_awburst = BURST_INCR.
- Read FSM states: R_IDLE, R_ADDR, R_DATA.
  - R_IDLE: grant to dcache if d_arvalid=1 and write FSM is W_IDLE; otherwise grant to icache if i_arvalid=1. Dcache has fixed priority.
  - On grant: the chosen port's arready pulses for exactly 1 cycle. ID, address and length are latched into AR registers. Next state is R_ADDR.
  - R_ADDR: m_arvalid=1 with registered payload held stable. Move to R_DATA on m_arvalid & m_arready.
  - R_DATA: demux by m_rid. Drive the owner's rvalid/rdata/rlast from the R channel; m_rready = owner's rready. The non-owner's rvalid stays 0.
  - Return to R_IDLE on the beat where m_rvalid & m_rready & m_rlast. A new grant is possible the next cycle (minimum 1 idle cycle between bursts).
- Write FSM states: W_IDLE, W_ADDR, W_DATA, W_RESP.
  - W_IDLE: on d_awvalid, pulse d_awready for 1 cycle, latch address/length, go to W_ADDR.
  - W_ADDR: m_awvalid=1; go to W_DATA on handshake.
  - W_DATA: W channel is combinational pass-through (m_wvalid=d_wvalid, d_wready=m_wready, data/strb/last forwarded). Beats before W_DATA are not accepted (d_wready=0). Go to W_RESP on the beat carrying wlast.
  - W_RESP: m_bready=d_bready and d_bvalid=m_bvalid. Return to W_IDLE on handshake.
- Hazard rule: a dcache read is never granted while the write FSM is not in W_IDLE, so write-back data reaches memory before the refill. Icache reads are unaffected.
- Simultaneous d_arvalid and i_arvalid in R_IDLE: dcache wins; the icache request stays pending (its arready stays 0).
- A non-zero m_rresp/m_bresp is ignored; data is still delivered.
- m_rid not matching the owner while in R_DATA: m_rready=0 and the beat is held. This is a protocol error and is asserted in simulation.
- Reset asserted mid-burst: immediate return to IDLE with all valids dropped. No recovery of the in-flight transaction.

Optional Feature:
- ARB_ROUND_ROBIN_EN defined: the read arbiter alternates priority. After serving dcache, icache has priority at the next R_IDLE, and vice versa. The write-idle hazard rule still gates dcache.
- Undefined: fixed dcache-over-icache priority.

Test Plan:
- Icache only: i_araddr=0x1C000000, i_arlen=3 -> m_arid=0, m_arlen=3, m_arsize=2; 4 beats delivered to i_rdata; i_rlast on beat 4; d_rvalid never 1.
- Simultaneous: i_araddr=0x100 and d_araddr=0x200 asserted in the same cycle -> d_arready first; m_araddr=0x200, m_arid=1; the icache burst follows after rlast. With ARB_ROUND_ROBIN_EN, a second simultaneous pair is served icache-first.
- Dirty eviction: AW=0x80000040 len 3 with 4 beats of wdata 0xA0..0xA3 and wstrb 0xF, while d_arvalid for 0x80000080 is pending -> the read is not issued until d_bvalid/d_bready completes; m_wlast on the 4th beat.
- Uncached store: AW len 0, wstrb 4'b0100, wdata 0x00AB0000 -> single beat with m_wlast=1; d_bvalid is returned.
- Backpressure: m_arready held 0 for 5 cycles -> m_araddr/m_arid stable throughout. d_rready=0 mid-burst -> m_rready=0; no beat lost or duplicated.
- Reset pulse during R_DATA beat 2 -> all outputs return to reset values asynchronously; the next request is arbitrated normally.
